// File: rtl/bram_addr_sequencer.sv
// Frame-interleaving address sequencer: reads a source BRAM in phase/stride order
// and writes the returned words linearly into a destination BRAM after RD_LAT cycles.
module bram_addr_sequencer #(
  parameter int PHASES = 4,
  parameter int STEPS  = 13,
  parameter int STRIDE = 4,
  parameter int RD_LAT = 1,
  parameter int A2_OFS = 1,
  parameter int B_OFS  = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stall,
  input  logic [10:0] base_a,
  input  logic [8:0]  base_b,
  output logic        ena,
  output logic [10:0] addra1,
  output logic [10:0] addra2,
  output logic        web,
  output logic [8:0]  addrb1,
  output logic [8:0]  addrb2,
  output logic        busy,
  output logic        done
);

  localparam int TOTAL = PHASES * STEPS;
  localparam int PH_W  = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam int ST_W  = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int N_W   = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q;
  logic [PH_W-1:0]   phase_q;
  logic [ST_W-1:0]   step_q;
  logic [10:0]       base_a_q;
  logic [8:0]        base_b_q;
  logic [N_W-1:0]    wcnt_q;
  logic [RD_LAT-1:0] pipe_q;
  logic              ena_q;
  logic              web_q;
  logic [10:0]       addra1_q;
  logic [10:0]       addra2_q;
  logic [8:0]        addrb1_q;
  logic [8:0]        addrb2_q;
  logic              busy_q;
  logic              done_q;

  logic [PH_W-1:0]   phase_cur_s;
  logic [PH_W-1:0]   phase_d;
  logic [ST_W-1:0]   step_cur_s;
  logic [ST_W-1:0]   step_d;
  logic [10:0]       base_a_cur_s;
  logic [10:0]       rd_addr_s;
  logic [8:0]        wr_addr_s;
  logic [RD_LAT:0]   pipe_ext_s;
  logic              issue_s;
  logic              last_s;

  // Read address and counter advance; in IDLE the first read uses the live base so it issues on the start edge
  always_comb begin
    base_a_cur_s = base_a_q;
    phase_cur_s  = phase_q;
    step_cur_s   = step_q;
    if (state_q == IDLE) begin
      base_a_cur_s = base_a;
      phase_cur_s  = '0;
      step_cur_s   = '0;
    end else begin
      base_a_cur_s = base_a_q;
    end

    rd_addr_s = base_a_cur_s + 11'(phase_cur_s) + 11'(STRIDE) * 11'(step_cur_s);
    last_s    = (phase_cur_s == PH_W'(PHASES - 1)) && (step_cur_s == ST_W'(STEPS - 1));

    phase_d = phase_cur_s;
    step_d  = step_cur_s;
    if (step_cur_s == ST_W'(STEPS - 1)) begin
      step_d  = '0;
      phase_d = phase_cur_s + PH_W'(1);
    end else begin
      step_d  = step_cur_s + ST_W'(1);
    end

    issue_s    = !stall && ((state_q == READ) || ((state_q == IDLE) && start));
    pipe_ext_s = {pipe_q, issue_s};
    wr_addr_s  = base_b_q + 9'(wcnt_q);
  end

  // Control FSM, read-valid pipeline and registered port outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      step_q   <= '0;
      base_a_q <= 11'd0;
      base_b_q <= 9'd0;
      wcnt_q   <= '0;
      pipe_q   <= '0;
      ena_q    <= 1'b0;
      web_q    <= 1'b0;
      addra1_q <= 11'd0;
      addra2_q <= 11'd0;
      addrb1_q <= 9'd0;
      addrb2_q <= 9'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // A stalled edge freezes the valid pipeline so each write keeps its RD_LAT distance
      if (!stall) begin
        ena_q  <= issue_s;
        pipe_q <= pipe_ext_s[RD_LAT-1:0];
        web_q  <= pipe_ext_s[RD_LAT];
        if (issue_s) begin
          addra1_q <= rd_addr_s;
          addra2_q <= rd_addr_s + 11'(A2_OFS);
        end
        if (pipe_ext_s[RD_LAT]) begin
          addrb1_q <= wr_addr_s;
          addrb2_q <= wr_addr_s + 9'(B_OFS);
          wcnt_q   <= wcnt_q + N_W'(1);
        end
      end else begin
        ena_q <= 1'b0;
        web_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= (issue_s && last_s) ? DRAIN : READ;
            base_a_q <= base_a;
            base_b_q <= base_b;
            busy_q   <= 1'b1;
            wcnt_q   <= '0;
            phase_q  <= issue_s ? phase_d : '0;
            step_q   <= issue_s ? step_d : '0;
          end
        end
        READ: begin
          if (issue_s) begin
            phase_q <= phase_d;
            step_q  <= step_d;
            if (last_s) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (wcnt_q == N_W'(TOTAL)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            wcnt_q  <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ena    = ena_q;
  assign addra1 = addra1_q;
  assign addra2 = addra2_q;
  assign web    = web_q;
  assign addrb1 = addrb1_q;
  assign addrb2 = addrb2_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_bram_addr_sequencer.sv
// Directed-vector bench for bram_addr_sequencer: two instances (RD_LAT 1 and 3)
// share stimulus; expected per-cycle outputs come from a cycle model of the frame rules.
module tb_bram_addr_sequencer;

  localparam int TOTAL  = 52;
  localparam int STEPS  = 13;
  localparam int STRIDE = 4;
  localparam int MAXV   = 1024;

  typedef struct packed {
    logic        ena;
    logic [10:0] a1;
    logic [10:0] a2;
    logic        web;
    logic [8:0]  b1;
    logic [8:0]  b2;
    logic        busy;
    logic        done;
  } exp_t;

  typedef struct {
    logic        rst;
    logic        start;
    logic        stall;
    logic [10:0] ba;
    logic [8:0]  bb;
    exp_t        e1;
    exp_t        e3;
    logic        hx;
    logic [10:0] hx_a1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic [10:0] base_a = 11'd0;
  logic [8:0]  base_b = 9'd0;

  logic        ena1, web1, busy1, done1;
  logic [10:0] addra1_1, addra2_1;
  logic [8:0]  addrb1_1, addrb2_1;
  logic        ena3, web3, busy3, done3;
  logic [10:0] addra1_3, addra2_3;
  logic [8:0]  addrb1_3, addrb2_3;

  always #5 clk = ~clk;

  bram_addr_sequencer #(.RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .base_a(base_a), .base_b(base_b),
    .ena(ena1), .addra1(addra1_1), .addra2(addra2_1), .web(web1),
    .addrb1(addrb1_1), .addrb2(addrb2_1), .busy(busy1), .done(done1)
  );

  bram_addr_sequencer #(.RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .base_a(base_a), .base_b(base_b),
    .ena(ena3), .addra1(addra1_3), .addra2(addra2_3), .web(web3),
    .addrb1(addrb1_3), .addrb2(addrb2_3), .busy(busy3), .done(done3)
  );

  vec_t        vt [MAXV];
  int          nv = 0;
  logic [10:0] cba = 11'd0;
  logic [8:0]  cbb = 9'd0;

  exp_t m_out [2];
  int   m_busy [2];
  int   m_rd [2];
  int   m_wr [2];
  int   m_u [2];
  int   m_ba [2];
  int   m_bb [2];
  int   m_iss [2][64];

  int n_vec = 0;
  int n_miss = 0;

  // One clock edge of the reference behaviour for model slot m with read latency lat
  task automatic model_edge(input int m, input int lat, input logic r, input logic s, input logic st);
    int a;
    int b;
    if (r) begin
      m_out[m] = '0;
      m_busy[m] = 0; m_rd[m] = 0; m_wr[m] = 0; m_u[m] = 0;
      return;
    end
    m_out[m].ena  = 1'b0;
    m_out[m].web  = 1'b0;
    m_out[m].done = 1'b0;
    if (m_busy[m] != 0 && m_wr[m] == TOTAL) begin
      m_out[m].done = 1'b1;
      m_out[m].busy = 1'b0;
      m_busy[m] = 0;
    end else if (m_busy[m] != 0 || s) begin
      if (m_busy[m] == 0) begin
        m_busy[m] = 1; m_rd[m] = 0; m_wr[m] = 0; m_u[m] = 0;
        m_ba[m] = int'(cba); m_bb[m] = int'(cbb);
        m_out[m].busy = 1'b1;
      end
      if (!st) begin
        m_u[m]++;
        if (m_wr[m] < m_rd[m] && m_u[m] == m_iss[m][m_wr[m]] + lat) begin
          b = (m_bb[m] + m_wr[m]) % 512;
          m_out[m].web = 1'b1;
          m_out[m].b1 = 9'(b);
          m_out[m].b2 = 9'((b + 256) % 512);
          m_wr[m]++;
        end
        if (m_rd[m] < TOTAL) begin
          a = (m_ba[m] + m_rd[m] / STEPS + STRIDE * (m_rd[m] % STEPS)) % 2048;
          m_out[m].ena = 1'b1;
          m_out[m].a1 = 11'(a);
          m_out[m].a2 = 11'((a + 1) % 2048);
          m_iss[m][m_rd[m]] = m_u[m];
          m_rd[m]++;
        end
      end
    end
  endtask

  task automatic add(input logic r, input logic s, input logic st);
    vt[nv].rst = r; vt[nv].start = s; vt[nv].stall = st;
    vt[nv].ba = cba; vt[nv].bb = cbb;
    model_edge(0, 1, r, s, st);
    model_edge(1, 3, r, s, st);
    vt[nv].e1 = m_out[0];
    vt[nv].e3 = m_out[1];
    vt[nv].hx = 1'b0;
    vt[nv].hx_a1 = 11'd0;
    nv++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) add(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    exp_t act1;
    exp_t act3;
    int   s2;
    int   last1;
    int   last3;
    int   hc [4];
    hc = '{2040, 2044, 0, 4};
    last1 = -100;
    last3 = -100;

    // Plain frame from base 0
    add(1'b1, 1'b0, 1'b0); add(1'b1, 1'b0, 1'b0);
    run(2);
    add(1'b0, 1'b1, 1'b0); run(60);

    // Wrapping bases
    cba = 11'd2040; cbb = 9'd500;
    s2 = nv;
    add(1'b0, 1'b1, 1'b0); run(60);
    for (int k = 0; k < 4; k++) begin
      vt[s2 + k].hx = 1'b1;
      vt[s2 + k].hx_a1 = 11'(hc[k]);
    end

    // Three stalled edges after the tenth read
    cba = 11'd0; cbb = 9'd0;
    add(1'b0, 1'b1, 1'b0); run(9);
    add(1'b0, 1'b0, 1'b1); add(1'b0, 1'b0, 1'b1); add(1'b0, 1'b0, 1'b1);
    run(60);

    // Start re-pulse while busy, then start held through done
    cba = 11'd100; cbb = 9'd7;
    add(1'b0, 1'b1, 1'b0); run(19);
    add(1'b0, 1'b1, 1'b0); run(30);
    cba = 11'd300; cbb = 9'd40;
    for (int k = 0; k < 30; k++) add(1'b0, 1'b1, 1'b0);
    run(60);

    // Reset mid-frame, then a fresh frame
    cba = 11'd0; cbb = 9'd0;
    add(1'b0, 1'b1, 1'b0); run(29);
    add(1'b1, 1'b0, 1'b0); run(3);
    add(1'b0, 1'b1, 1'b0); run(60);

    for (int i = 0; i < nv; i++) begin
      @(negedge clk);
      rst = vt[i].rst; start = vt[i].start; stall = vt[i].stall;
      base_a = vt[i].ba; base_b = vt[i].bb;
      @(posedge clk);
      #1;
      act1 = '{ena1, addra1_1, addra2_1, web1, addrb1_1, addrb2_1, busy1, done1};
      act3 = '{ena3, addra1_3, addra2_3, web3, addrb1_3, addrb2_3, busy3, done3};
      n_vec++;
      if (act1 !== vt[i].e1) begin
        n_miss++;
        $display("FAIL vec%0d lat1 got %h want %h", i, act1, vt[i].e1);
      end
      n_vec++;
      if (act3 !== vt[i].e3) begin
        n_miss++;
        $display("FAIL vec%0d lat3 got %h want %h", i, act3, vt[i].e3);
      end
      if (vt[i].hx) begin
        n_vec++;
        if (addra1_1 !== vt[i].hx_a1 || ena1 !== 1'b1) begin
          n_miss++;
          $display("FAIL vec%0d wrap_addra1 got %0d ena %b want %0d", i, addra1_1, ena1, vt[i].hx_a1);
        end
      end
      if (done1 === 1'b1) begin
        n_vec++;
        if (i - last1 != 2) begin
          n_miss++;
          $display("FAIL vec%0d lat1_done_gap got %0d want 2", i, i - last1);
        end
      end
      if (done3 === 1'b1) begin
        n_vec++;
        if (i - last3 != 4) begin
          n_miss++;
          $display("FAIL vec%0d lat3_done_gap got %0d want 4", i, i - last3);
        end
      end
      if (ena1 === 1'b1) last1 = i;
      if (ena3 === 1'b1) last3 = i;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/bram_addr_sequencer.md
BRAM_ADDR_SEQUENCER -- requirements
Module: bram_addr_sequencer

Interface
REQ-001 SHALL have parameter PHASES, 4, number of interleave phases per frame.
REQ-002 SHALL have parameter STEPS, 13, reads per phase.
REQ-003 SHALL have parameter STRIDE, 4, port-A address increment within a phase.
REQ-004 SHALL have parameter RD_LAT, 1, source BRAM read latency in cycles (1..3).
REQ-005 SHALL have parameter A2_OFS, 1, offset of addra2 from addra1.
REQ-006 SHALL have parameter B_OFS, 256, offset of addrb2 from addrb1.
REQ-007 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-008 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port start, input, 1, begin a frame transfer (level sampled in IDLE).
REQ-010 SHALL have port stall, input, 1, destination not ready; freezes the transfer.
REQ-011 SHALL have port base_a, input, 11, source base address, sampled with start.
REQ-012 SHALL have port base_b, input, 9, destination base address, sampled with start.
REQ-013 SHALL have port ena, output, 1, source read enable (both A ports).
REQ-014 SHALL have ports addra1/addra2, output, 11 each, source read addresses.
REQ-015 SHALL have port web, output, 1, destination write enable (both B ports).
REQ-016 SHALL have ports addrb1/addrb2, output, 9 each, destination write addresses.
REQ-017 SHALL have ports busy, output, 1 (transfer in progress) and done, output, 1 (one-cycle completion pulse).

Function
REQ-018 SHALL implement FSM states IDLE, READ, DRAIN; all outputs registered.
REQ-019 IDLE: start=1 at an edge -> READ; latch base_a, base_b; phase=0, step=0; busy=1.
REQ-020 READ, stall=0: ena=1, addra1=base_a+phase+STRIDE*step, addra2=addra1+A2_OFS; then step++; at step=STEPS-1 step->0, phase++.
REQ-021 READ: after issuing phase=PHASES-1, step=STEPS-1 -> DRAIN.
REQ-022 Write n (n=0..PHASES*STEPS-1, issue order) SHALL assert web exactly RD_LAT un-stalled cycles after read n's ena cycle, with addrb1=base_b+n, addrb2=addrb1+B_OFS.
REQ-023 stall=1 SHALL force ena=0 and web=0 and freeze counters and the RD_LAT valid pipeline; resume exactly where stopped when stall drops.
REQ-024 DRAIN: continue writes until pipeline empty, then -> IDLE, busy=0, done=1 for one cycle.
REQ-025 Address arithmetic SHALL wrap modulo 2^11 (port A) and 2^9 (port B); no saturation, no error flag.
REQ-026 start while busy=1 SHALL be ignored; start held high in the done cycle SHALL begin a new frame on the next edge.
REQ-027 With stall=0 throughout, a frame SHALL take PHASES*STEPS ena cycles followed by done exactly RD_LAT+1 cycles after the last ena cycle.
REQ-028 ena and web MAY be high in the same cycle (pipelined overlap).

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, ena=0, web=0, busy=0, done=0, addra1=addra2=0, addrb1=addrb2=0, counters and valid pipeline cleared.
REQ-030 rst asserted mid-frame SHALL abort the frame without a done pulse; the first start after rst release starts a fresh frame at phase 0, step 0.

Verification
REQ-031 base_a=0, base_b=0, start pulse, stall=0 -> addra1 sequence 0,4,...,48,1,5,...,49,2,...,50,3,...,51 (52 ena cycles); addra2=addra1+1; web cycles addrb1=0..51, addrb2=256..307; one done pulse.
REQ-032 base_a=2040, base_b=500, start -> addra1 first values 2040,2044,0,4 (wrap); addrb1 500..511 then 0..39; addrb2=addrb1+256 mod 512.
REQ-033 stall=1 for 3 cycles after the 10th read -> no ena/web in those cycles; remaining addresses identical to REQ-031; done delayed exactly 3 cycles.
REQ-034 start re-pulsed at read 20 -> ignored, sequence unchanged; start held high through done -> second frame begins next cycle at addra1=base_a.
REQ-035 rst pulse at read 30 -> all outputs 0 that cycle, no done; subsequent start produces the full REQ-031 sequence.
REQ-036 RD_LAT=3, base 0 -> web n lags ena n by 3 cycles; done 4 cycles after last ena.
